// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready flow control.
// Applies one of eight bitwise operations (selected per transaction by op) to
// WIDTH-bit operands a and b. Stage 1 holds the operands, stage 2 holds the result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand transaction offered
//   in_ready   block accepts a transaction this cycle (combinational from out_ready)
//   a, b       WIDTH-bit operands
//   op         opcode: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT A, 7 PASS A
//   out_valid  result on y is valid
//   out_ready  consumer accepts the result this cycle
//   y          WIDTH-bit result
//   zero       y is all zeros (qualified by out_valid)
//   popcnt     number of 1 bits in y (only when LOGIC_UNIT_PIPE_POPCNT_EN is defined)
//
// Build option: define LOGIC_UNIT_PIPE_POPCNT_EN to add the registered popcnt output.

module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND = 3'd4;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    // Stage 1: captured operands
    logic             v1;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OP_W-1:0]  op_q;

    // Stage 2: registered result
    logic             v2;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;

    logic             adv1;
    logic             adv2;
    logic [WIDTH-1:0] res_c;

    // Flow control: a stage may load when it is empty or its contents move on.
    assign adv2 = !v2 || out_ready;
    assign adv1 = !v1 || adv2;

    // Held high through reset so the source never sees a spurious stall there.
    assign in_ready  = rst || adv1;
    assign out_valid = v2;
    assign y         = y_q;
    assign zero      = zero_q;

    // Stage 1 register: valid follows in_valid whenever the stage advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
        end
    end

    // Bitwise operation on the stage-1 operands.
    always_comb begin
        res_c = '0;
        unique case (op_q)
            OP_AND:  res_c = a_q & b_q;
            OP_OR:   res_c = a_q | b_q;
            OP_XOR:  res_c = a_q ^ b_q;
            OP_XNOR: res_c = ~(a_q ^ b_q);
            OP_NAND: res_c = ~(a_q & b_q);
            OP_NOR:  res_c = ~(a_q | b_q);
            OP_NOTA: res_c = ~a_q;
            OP_PASS: res_c = a_q;
            default: res_c = '0;
        endcase
    end

    // Stage 2 register: result data only changes when a real item moves in.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            y_q    <= '0;
            zero_q <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                y_q    <= res_c;
                zero_q <= (res_c == '0);
            end
        end
    end

`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
    localparam int unsigned PC_W = $clog2(WIDTH + 1);

    logic [PC_W-1:0] pc_c;
    logic [PC_W-1:0] pc_q;

    // Population count of the result being loaded into stage 2.
    always_comb begin
        pc_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pc_c = pc_c + PC_W'(res_c[i]);
        end
    end

    // Tracks y: same load condition, so it holds through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (adv2 && v1) begin
            pc_q <= pc_c;
        end
    end

    assign popcnt = pc_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: WIDTH=8 instance exercised with directed and
// random traffic against a truth-table reference model and a result queue,
// plus a WIDTH=1 instance for the single-bit case.

module tb_logic_unit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       zero;

    logic       w_in_valid;
    logic       w_in_ready;
    logic [0:0] w_a;
    logic [0:0] w_b;
    logic [2:0] w_op;
    logic       w_out_valid;
    logic       w_out_ready;
    logic [0:0] w_y;
    logic       w_zero;

`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
    logic [3:0] popcnt;
    logic [0:0] w_popcnt;
`endif

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero)
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
        ,
        .popcnt    (popcnt)
`endif
    );

    logic_unit_pipe #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .a         (w_a),
        .b         (w_b),
        .op        (w_op),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .y         (w_y),
        .zero      (w_zero)
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
        ,
        .popcnt    (w_popcnt)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;
    int in_cnt   = 0;
    int out_cnt  = 0;

    logic [7:0] exp_q[$];

    // Values sampled at the most recent falling edge
    logic       s_ov;
    logic       s_ir;
    logic [7:0] s_y;
    logic       s_z;
    logic       s1_ov;
    logic [0:0] s1_y;
    logic       s1_z;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_y    = '0;

    // Reference: each opcode is a 2-input truth table applied bit by bit,
    // indexed by {a_bit, b_bit}.
    function automatic logic [7:0] ref_y(input logic [7:0] ai, input logic [7:0] bi,
                                         input logic [2:0] o);
        logic [3:0] tt [8];
        logic [3:0] row;
        logic [7:0] r;
        tt = '{4'b1000, 4'b1110, 4'b0110, 4'b1001, 4'b0111, 4'b0001, 4'b0011, 4'b1100};
        row = tt[o];
        for (int i = 0; i < 8; i++) r[i] = row[{ai[i], bi[i]}];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, score handshakes, then
    // return 1 time unit after the rising edge so inputs can be changed.
    task automatic cycle();
        @(negedge clk);
        s_ov  = out_valid;
        s_ir  = in_ready;
        s_y   = y;
        s_z   = zero;
        s1_ov = w_out_valid;
        s1_y  = w_y;
        s1_z  = w_zero;
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
                chk("stall_hold_y", 32'(y), 32'(prev_y));
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("sb_y", 32'(y), 32'(e));
                    chk("sb_zero", 32'(zero), 32'(e == 8'h00));
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
                    chk("sb_popcnt", 32'(popcnt), 32'($countones(e)));
`endif
                end
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_y(a, b, op));
                in_cnt++;
            end
            prev_hold = out_valid && !out_ready;
            prev_y    = y;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tbl [8];
        logic [7:0] bp_a [4];
        logic [7:0] bp_b [4];
        logic [2:0] bp_op [4];
        logic [7:0] held_y;
        int idx;
        int guard;

        tbl = '{8'h30, 8'hFC, 8'hCC, 8'h33, 8'hCF, 8'h03, 8'h0F, 8'hF0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0; w_op = '0;

        // Reset state
        cycle();
        cycle();
        chk("in_ready_during_reset", 32'(s_ir), 32'd1);
        rst = 1'b0;
        cycle();
        chk("rst_out_valid", 32'(s_ov), 32'd0);
        chk("rst_y", 32'(s_y), 32'd0);
        chk("rst_zero", 32'(s_z), 32'd0);
        chk("rst_in_ready", 32'(s_ir), 32'd1);
        chk("rst_w1_out_valid", 32'(s1_ov), 32'd0);

        // All eight opcodes back to back, result two cycles after the offer
        out_ready = 1'b1; a = 8'hF0; b = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            op = 3'(i);
            cycle();
            if (i >= 2) begin
                chk("ops_out_valid", 32'(s_ov), 32'd1);
                chk("ops_y", 32'(s_y), 32'(tbl[i-2]));
            end else begin
                chk("ops_latency_out_valid", 32'(s_ov), 32'd0);
            end
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("ops_drained", 32'(s_ov), 32'd0);

        // Zero flag and popcount
        a = 8'hAA; b = 8'hAA; op = 3'd2; in_valid = 1'b1;
        cycle();
        op = 3'd1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("xor_self_y", 32'(s_y), 32'h00);
        chk("xor_self_zero", 32'(s_z), 32'd1);
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
        chk("xor_self_popcnt", 32'(popcnt), 32'd0);
`endif
        cycle();
        chk("or_self_y", 32'(s_y), 32'hAA);
        chk("or_self_zero", 32'(s_z), 32'd0);
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
        chk("or_self_popcnt", 32'(popcnt), 32'd4);
`endif
        cycle();

        // Backpressure: only two transactions fit while the consumer stalls
        for (int i = 0; i < 4; i++) begin
            bp_a[i]  = 8'($urandom);
            bp_b[i]  = 8'($urandom);
            bp_op[i] = 3'($urandom);
        end
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; a = bp_a[idx]; b = bp_b[idx]; op = bp_op[idx];
            cycle();
            chk("bp_in_ready", 32'(s_ir), 32'(c < 2));
            if (c >= 2) chk("bp_y_stable", 32'(s_y), 32'(ref_y(bp_a[0], bp_b[0], bp_op[0])));
            if (s_ir) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        out_ready = 1'b1;
        guard = 0;
        while (idx < 4 && guard < 20) begin
            in_valid = 1'b1; a = bp_a[idx]; b = bp_b[idx]; op = bp_op[idx];
            cycle();
            if (s_ir) idx++;
            guard++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd4);
        in_valid = 1'b0;
        repeat (4) cycle();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Random valid/ready traffic
        in_cnt = 0; out_cnt = 0; guard = 0;
        while (in_cnt < 1000 && guard < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            guard++;
        end
        chk("rand_sent_1000", 32'(in_cnt), 32'd1000);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) cycle();
        chk("rand_in_eq_out", 32'(out_cnt), 32'(in_cnt));
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with both stages full discards everything
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'h5A; b = 8'h0F; op = 3'd1;
        cycle();
        a = 8'h33; op = 3'd7;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("full_before_reset", 32'(s_ov), 32'd1);
        chk("full_in_ready", 32'(s_ir), 32'd0);
        rst = 1'b1;
        cycle();
        chk("in_ready_in_reset_full", 32'(s_ir), 32'd1);
        rst = 1'b0;
        cycle();
        chk("post_rst_out_valid", 32'(s_ov), 32'd0);
        chk("post_rst_y", 32'(s_y), 32'd0);
        chk("post_rst_zero", 32'(s_z), 32'd0);
        chk("post_rst_in_ready", 32'(s_ir), 32'd1);
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
        chk("post_rst_popcnt", 32'(popcnt), 32'd0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("no_stale_output", 32'(s_ov), 32'd0);
        end

        // WIDTH = 1 instance
        w_in_valid = 1'b1; w_a = 1'b1; w_b = 1'b0; w_op = 3'd4;
        cycle();
        w_op = 3'd0;
        cycle();
        w_in_valid = 1'b0;
        cycle();
        chk("w1_nand_valid", 32'(s1_ov), 32'd1);
        chk("w1_nand_y", 32'(s1_y), 32'd1);
        chk("w1_nand_zero", 32'(s1_z), 32'd0);
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
        chk("w1_nand_popcnt", 32'(w_popcnt), 32'd1);
`endif
        cycle();
        chk("w1_and_y", 32'(s1_y), 32'd0);
        chk("w1_and_zero", 32'(s1_z), 32'd1);
        cycle();
        chk("w1_drained", 32'(s1_ov), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
